// File: rtl/motor_tach_multi.sv
// Multi-channel tachometer: synchronised, glitch-filtered rising-edge counts per gate window,
// published once per window with saturation flags and stall detection.
module motor_tach_multi #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GATE_CYCLES   = 50_000_000,
  parameter int unsigned FILT_LEN      = 4,
  parameter int unsigned STALL_WINDOWS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       pulse_in,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic                    sample_valid,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       stall
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned RUN_W  = $clog2(STALL_WINDOWS + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(STALL_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [NUM_CH-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_CH-1:0]             filt_q, filt_d;
  logic [NUM_CH-1:0][FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [GATE_W-1:0]             gate_q, gate_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  acc_q, acc_d;
  logic [NUM_CH-1:0]             ovf_q, ovf_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  count_q, count_d;
  logic [NUM_CH-1:0]             overflow_q, overflow_d;
  logic [NUM_CH-1:0][RUN_W-1:0]  run_q, run_d;
  logic [NUM_CH-1:0]             stall_q, stall_d;
  logic                          sample_valid_q, sample_valid_d;
  logic [NUM_CH-1:0]             edge_c;
  logic                          terminal_c;

  always_comb begin
    sync1_d        = pulse_in;
    sync2_d        = sync1_q;
    filt_d         = filt_q;
    filt_cnt_d     = filt_cnt_q;
    gate_d         = gate_q;
    acc_d          = acc_q;
    ovf_d          = ovf_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    run_d          = run_q;
    stall_d        = stall_q;
    edge_c         = '0;
    terminal_c     = enable && (gate_q == '0);
    sample_valid_d = terminal_c;

    // Filter: accept a new level only after FILT_LEN consecutive differing samples
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (filt_cnt_q[i] == FILT_LAST) begin
          filt_d[i]     = sync2_q[i];
          filt_cnt_d[i] = '0;
        end else begin
          filt_cnt_d[i] = filt_cnt_q[i] + 1'b1;
        end
      end else begin
        filt_cnt_d[i] = '0;
      end
      edge_c[i] = filt_d[i] & ~filt_q[i];
    end

    if (!enable || terminal_c) gate_d = GATE_LAST;
    else                       gate_d = gate_q - 1'b1;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!enable) begin
        acc_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (terminal_c) begin
        count_d[i]    = acc_q[i];
        overflow_d[i] = ovf_q[i];
        if (acc_q[i] == '0) begin
          if (run_q[i] != RUN_MAX) run_d[i] = run_q[i] + 1'b1;
        end else begin
          run_d[i] = '0;
        end
        stall_d[i] = (run_d[i] == RUN_MAX);
        // an edge on the terminal cycle opens the next window
        acc_d[i]   = CNT_W'(edge_c[i]);
        ovf_d[i]   = 1'b0;
      end else if (edge_c[i]) begin
        if (acc_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     acc_d[i] = acc_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      filt_q         <= '0;
      filt_cnt_q     <= '0;
      gate_q         <= GATE_LAST;
      acc_q          <= '0;
      ovf_q          <= '0;
      count_q        <= '0;
      overflow_q     <= '0;
      run_q          <= '0;
      stall_q        <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      filt_q         <= filt_d;
      filt_cnt_q     <= filt_cnt_d;
      gate_q         <= gate_d;
      acc_q          <= acc_d;
      ovf_q          <= ovf_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      run_q          <= run_d;
      stall_q        <= stall_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign count_out    = count_q;
  assign sample_valid = sample_valid_q;
  assign overflow     = overflow_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_motor_tach_multi.sv
// Bench for motor_tach_multi: dut_a uses FILT_LEN=4/STALL_WINDOWS=2, dut_b uses FILT_LEN=1/
// STALL_WINDOWS=1 so saturation is reachable inside a 100-cycle window.
module tb_motor_tach_multi;

  localparam int GATE = 100;
  localparam int SW_A = 2;
  localparam int SW_B = 1;

  logic       clk, rst_n, enable;
  logic [1:0] pulse_a, pulse_b;
  logic [7:0] count_a, count_b;
  logic       sv_a, sv_b;
  logic [1:0] ovf_a, ovf_b, stall_a, stall_b;

  int vec, miss;
  int run_a[2], run_b[2];
  logic [11:0] exp_a, exp_b;

  motor_tach_multi #(.NUM_CH(2), .CNT_W(4), .GATE_CYCLES(GATE), .FILT_LEN(4),
                     .STALL_WINDOWS(SW_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_a),
    .count_out(count_a), .sample_valid(sv_a), .overflow(ovf_a), .stall(stall_a));

  motor_tach_multi #(.NUM_CH(2), .CNT_W(4), .GATE_CYCLES(GATE), .FILT_LEN(1),
                     .STALL_WINDOWS(SW_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_b),
    .count_out(count_b), .sample_valid(sv_b), .overflow(ovf_b), .stall(stall_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of one completed window: n = clean rising edges seen by a channel.
  // Returns {count_out, overflow, stall} and advances the zero-window run per channel.
  function automatic logic [11:0] win(input bit is_b, input int n0, input int n1);
    int n[2];
    int r;
    int sw;
    logic [11:0] v;
    n[0] = n0; n[1] = n1; v = '0;
    sw = is_b ? SW_B : SW_A;
    for (int c = 0; c < 2; c++) begin
      v[4 + c*4 +: 4] = 4'((n[c] > 15) ? 15 : n[c]);
      v[2 + c] = (n[c] > 15);
      r = is_b ? run_b[c] : run_a[c];
      if (n[c] == 0) r = (r < sw) ? r + 1 : r;
      else           r = 0;
      if (is_b) run_b[c] = r; else run_a[c] = r;
      v[c] = (r == sw);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sv(output int n);
    n = 0;
    while (!sv_a && n < 3*GATE) begin
      tick();
      n++;
    end
  endtask

  // Clean pulse trains starting right after a window opens, len cycles long.
  task automatic drive(input int na0, input int na1, input int ha, input int la,
                       input int nb0, input int nb1, input int hb, input int lb, input int len);
    for (int t = 0; t < len; t++) begin
      pulse_a[0] = (t < na0*(ha+la)) && ((t % (ha+la)) < ha);
      pulse_a[1] = (t < na1*(ha+la)) && ((t % (ha+la)) < ha);
      pulse_b[0] = (t < nb0*(hb+lb)) && ((t % (hb+lb)) < hb);
      pulse_b[1] = (t < nb1*(hb+lb)) && ((t % (hb+lb)) < hb);
      tick();
    end
    pulse_a = '0;
    pulse_b = '0;
  endtask

  // Runs one window of clean trains and checks the strobe timing and published results.
  task automatic window(input string nm, input int na0, input int na1, input int ha, input int la,
                        input int nb0, input int nb1, input int hb, input int lb, input int len);
    int n;
    drive(na0, na1, ha, la, nb0, nb1, hb, lb, len);
    wait_sv(n);
    exp_a = win(1'b0, na0, na1);
    exp_b = win(1'b1, nb0, nb1);
    vec++;
    if (len + n !== GATE) begin
      miss++; $display("FAIL %s strobe period got %0d want %0d", nm, len + n, GATE);
    end
    vec++;
    if ({count_a, ovf_a, stall_a} !== exp_a) begin
      miss++; $display("FAIL %s dut_a {cnt,ovf,stall} got %h want %h", nm, {count_a, ovf_a, stall_a}, exp_a);
    end
    vec++;
    if ({count_b, ovf_b, stall_b, sv_b} !== {exp_b, 1'b1}) begin
      miss++; $display("FAIL %s dut_b {cnt,ovf,stall,sv} got %h want %h", nm, {count_b, ovf_b, stall_b, sv_b}, {exp_b, 1'b1});
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; enable = 1'b0; pulse_a = '0; pulse_b = '0;
    run_a = '{0, 0}; run_b = '{0, 0};
    repeat (3) tick();
    vec++;
    if ({count_a, ovf_a, stall_a, sv_a, count_b, ovf_b, stall_b, sv_b} !== 26'd0) begin
      miss++; $display("FAIL reset_outputs got %h want 0", {count_a, ovf_a, stall_a, sv_a, count_b, ovf_b, stall_b, sv_b});
    end
    rst_n = 1'b1; enable = 1'b1;
    wait_sv(n);
    // counting the enable cycle as cycle 1
    vec++;
    if (n + 1 !== GATE + 1) begin
      miss++; $display("FAIL first_strobe cycle got %0d want %0d", n + 1, GATE + 1);
    end
    exp_a = win(1'b0, 0, 0);
    exp_b = win(1'b1, 0, 0);
    vec++;
    if ({count_a, ovf_a, stall_a, count_b, ovf_b, stall_b} !== {exp_a, exp_b}) begin
      miss++; $display("FAIL first_window got %h want %h", {count_a, ovf_a, stall_a, count_b, ovf_b, stall_b}, {exp_a, exp_b});
    end
    tick();
    vec++;
    if ({sv_a, sv_b} !== 2'b00) begin
      miss++; $display("FAIL strobe_width got %b want 00", {sv_a, sv_b});
    end
    wait_sv(n);
    vec++;
    if (n + 1 !== GATE) begin
      miss++; $display("FAIL strobe_repeat got %0d want %0d", n + 1, GATE);
    end
    exp_a = win(1'b0, 0, 0);
    exp_b = win(1'b1, 0, 0);
    vec++;
    if ({count_a, ovf_a, stall_a, count_b, ovf_b, stall_b} !== {exp_a, exp_b}) begin
      miss++; $display("FAIL second_window got %h want %h", {count_a, ovf_a, stall_a, count_b, ovf_b, stall_b}, {exp_a, exp_b});
    end
  endtask

  task automatic test_counts();
    window("counts_10_3", 10, 3, 5, 5, 0, 0, 1, 1, 100);
  endtask

  task automatic test_glitch();
    int n;
    for (int g = 0; g < 6; g++) begin
      pulse_a[0] = 1'b1; repeat (3) tick();
      pulse_a[0] = 1'b0; repeat (5) tick();
    end
    for (int p = 0; p < 2; p++) begin
      pulse_a[0] = 1'b1; repeat (4) tick();
      pulse_a[0] = 1'b0; repeat (5) tick();
    end
    wait_sv(n);
    exp_a = win(1'b0, 2, 0);
    exp_b = win(1'b1, 0, 0);
    vec++;
    if ({count_a, ovf_a, stall_a} !== exp_a) begin
      miss++; $display("FAIL glitch dut_a got %h want %h", {count_a, ovf_a, stall_a}, exp_a);
    end
    vec++;
    if (66 + n !== GATE) begin
      miss++; $display("FAIL glitch strobe period got %0d want %0d", 66 + n, GATE);
    end
  endtask

  task automatic test_overflow();
    window("ovf_20", 0, 0, 5, 5, 20, 0, 2, 2, 80);
    window("ovf_recover_5", 0, 0, 5, 5, 5, 0, 2, 2, 20);
  endtask

  task automatic test_stall();
    window("stall_w1", 0, 1, 5, 5, 0, 0, 1, 1, 10);
    window("stall_w2", 0, 0, 5, 5, 0, 0, 1, 1, 10);
    window("stall_w3", 0, 0, 5, 5, 0, 0, 1, 1, 10);
    vec++;
    if (stall_a[1] !== 1'b1) begin
      miss++; $display("FAIL stall_set got %b want 1", stall_a[1]);
    end
    window("stall_w4", 0, 1, 5, 5, 0, 0, 1, 1, 10);
    vec++;
    if (stall_a[1] !== 1'b0) begin
      miss++; $display("FAIL stall_clear got %b want 0", stall_a[1]);
    end
  endtask

  task automatic test_random();
    int nb0;
    for (int w = 0; w < 8; w++) begin
      nb0 = (w == 0) ? 15 : (w == 1) ? 16 : int'($urandom_range(0, 30));
      window("random", int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
             int'($urandom_range(4, 5)), int'($urandom_range(4, 5)),
             nb0, int'($urandom_range(0, 30)), 1, 1, 90);
    end
  endtask

  task automatic test_enable_hold();
    int n;
    int seen;
    drive(3, 0, 5, 5, 0, 0, 1, 1, 40);
    enable = 1'b0;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (sv_a || sv_b) seen++;
    end
    vec++;
    if (seen !== 0) begin
      miss++; $display("FAIL disabled_strobes got %0d want 0", seen);
    end
    vec++;
    if ({count_a, ovf_a, stall_a, count_b, ovf_b, stall_b} !== {exp_a, exp_b}) begin
      miss++; $display("FAIL disabled_hold got %h want %h", {count_a, ovf_a, stall_a, count_b, ovf_b, stall_b}, {exp_a, exp_b});
    end
    enable = 1'b1;
    window("reenable", 2, 0, 5, 5, 0, 0, 1, 1, 20);
  endtask

  task automatic test_terminal_edge();
    int n;
    repeat (GATE - 6) tick();
    pulse_a[0] = 1'b1;
    repeat (6) tick();
    pulse_a[0] = 1'b0;
    wait_sv(n);
    exp_a = win(1'b0, 0, 0);
    exp_b = win(1'b1, 0, 0);
    vec++;
    if ({count_a, ovf_a, stall_a} !== exp_a) begin
      miss++; $display("FAIL terminal_excluded got %h want %h", {count_a, ovf_a, stall_a}, exp_a);
    end
    tick();
    wait_sv(n);
    exp_a = win(1'b0, 1, 0);
    exp_b = win(1'b1, 0, 0);
    vec++;
    if ({count_a, ovf_a, stall_a} !== exp_a) begin
      miss++; $display("FAIL terminal_carried got %h want %h", {count_a, ovf_a, stall_a}, exp_a);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive(0, 2, 5, 5, 3, 0, 1, 1, 49);
    rst_n = 1'b0;
    tick();
    vec++;
    if ({count_a, ovf_a, stall_a, sv_a, count_b, ovf_b, stall_b, sv_b} !== 26'd0) begin
      miss++; $display("FAIL mid_reset_outputs got %h want 0", {count_a, ovf_a, stall_a, sv_a, count_b, ovf_b, stall_b, sv_b});
    end
    run_a = '{0, 0}; run_b = '{0, 0};
    rst_n = 1'b1;
    wait_sv(n);
    vec++;
    if (n + 1 !== GATE + 1) begin
      miss++; $display("FAIL mid_reset_strobe cycle got %0d want %0d", n + 1, GATE + 1);
    end
    exp_a = win(1'b0, 0, 0);
    exp_b = win(1'b1, 0, 0);
    vec++;
    if ({count_a, ovf_a, stall_a, count_b, ovf_b, stall_b} !== {exp_a, exp_b}) begin
      miss++; $display("FAIL mid_reset_discard got %h want %h", {count_a, ovf_a, stall_a, count_b, ovf_b, stall_b}, {exp_a, exp_b});
    end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    test_reset();
    test_counts();
    test_glitch();
    test_overflow();
    test_stall();
    test_random();
    test_enable_hold();
    test_terminal_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
